// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master transfer controller.
// Optional LSB-first support is enabled by SPI_MASTER_CTRL_LSBFIRST_EN.
package spi_pkg;

    localparam int unsigned DATA_WIDTH_DEF      = 8;
    localparam int unsigned PRESCALAR_WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Shared TX/RX shift register: parallel load, one-bit shift, MSB- or LSB-first.
// d_o exposes the next-state value so a final shift can be captured in the same cycle.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int unsigned Width = DATA_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             shift_i,
    input  logic             sin_i,
    input  logic             lsb_first_i,
    output logic [Width-1:0] d_o,
    output logic             sout_o
);

    logic [Width-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = data_i;
        end else if (shift_i) begin
            sreg_d = lsb_first_i ? {sin_i, sreg_q[Width-1:1]}
                                 : {sreg_q[Width-2:0], sin_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign d_o    = sreg_d;
    assign sout_o = lsb_first_i ? sreg_q[0] : sreg_q[Width-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transfer controller: sequences the baud generator and the shift path.
// Define SPI_MASTER_CTRL_LSBFIRST_EN to add the lsb_first_i bit-order select.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DataWidth      = DATA_WIDTH_DEF,
    parameter int unsigned PrescalarWidth = PRESCALAR_WIDTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      spe_i,
    input  logic                      start_i,
    input  logic [DataWidth-1:0]      tx_data_i,
    input  logic                      cpol_i,
    input  logic                      cpha_i,
    input  logic [PrescalarWidth-1:0] spr_i,
`ifdef SPI_MASTER_CTRL_LSBFIRST_EN
    input  logic                      lsb_first_i,
`endif
    input  logic                      brg_baud_i,
    output logic                      brg_en_o,
    output logic                      brg_clr_o,
    output logic [PrescalarWidth-1:0] brg_spr_o,
    output logic                      ss_n_o,
    output logic                      sck_o,
    output logic                      mosi_o,
    input  logic                      miso_i,
    output logic [DataWidth-1:0]      rx_data_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned CntW = $clog2(2 * DataWidth);
    localparam logic [CntW-1:0] LastEdge = CntW'(2 * DataWidth - 1);

    state_e                    state_q, state_d;
    logic                      cpol_q, cpha_q, lsb_q;
    logic [PrescalarWidth-1:0] spr_q;
    logic                      baud_q, sck_q, sck_d, miso_q;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [DataWidth-1:0]      rx_q, sreg_nxt;
    logic                      tick, odd, last;
    logic                      load, shift, sample, done, sout;

    assign tick = brg_baud_i ^ baud_q;
    assign odd  = ~cnt_q[0];
    assign last = (cnt_q == LastEdge);

    always_comb begin
        state_d = state_q;
        sck_d   = sck_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        sample  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                sck_d = cpol_i;
                if (start_i && spe_i) begin
                    state_d = SETUP;
                    load    = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = XFER;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (tick) begin
                    sck_d  = ~sck_q;
                    cnt_d  = cnt_q + 1'b1;
                    sample = cpha_q ? ~odd : odd;
                    shift  = cpha_q ? (odd && cnt_q != '0) : ~odd;
                    if (last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // cpha=1 samples on the last edge; fold that bit in here
                if (tick) begin
                    state_d = IDLE;
                    done    = 1'b1;
                    shift   = cpha_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!spe_i) begin
            state_d = IDLE;
            sck_d   = (state_q == IDLE) ? cpol_i : cpol_q;
            load    = 1'b0;
            shift   = 1'b0;
            sample  = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            spr_q   <= '0;
            baud_q  <= 1'b0;
            sck_q   <= 1'b0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            sck_q   <= sck_d;
            cnt_q   <= cnt_d;
            baud_q  <= (state_q == IDLE) ? 1'b0 : brg_baud_i;
            if (load) begin
                cpol_q <= cpol_i;
                cpha_q <= cpha_i;
                spr_q  <= spr_i;
            end
            if (sample) begin
                miso_q <= miso_i;
            end
            if (done) begin
                rx_q <= sreg_nxt;
            end
        end
    end

`ifdef SPI_MASTER_CTRL_LSBFIRST_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lsb_q <= 1'b0;
        end else if (load) begin
            lsb_q <= lsb_first_i;
        end
    end
`else
    assign lsb_q = 1'b0;
`endif

    spi_shift_reg #(
        .Width (DataWidth)
    ) u_shift (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load),
        .data_i      (tx_data_i),
        .shift_i     (shift),
        .sin_i       (miso_q),
        .lsb_first_i (lsb_q),
        .d_o         (sreg_nxt),
        .sout_o      (sout)
    );

    assign brg_en_o  = (state_q != IDLE);
    assign brg_clr_o = (state_q == IDLE);
    assign brg_spr_o = spr_q;
    assign ss_n_o    = (state_q == IDLE);
    assign sck_o     = sck_q;
    assign mosi_o    = (state_q != IDLE) & sout;
    assign rx_data_o = rx_q;
    assign busy_o    = (state_q != IDLE) & ~done;
    assign done_o    = done;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a baud-generator model, SPI slave
// model and scoreboard queues for expected MOSI bits and received words.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       spe = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx = 8'h00;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [2:0] spr = 3'd0;
    logic       brg_baud, brg_en, brg_clr;
    logic [2:0] brg_spr;
    logic       ss_n, sck, mosi, miso;
    logic [7:0] rx;
    logic       busy, done;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         t_start = 0;
    logic [7:0] bcnt = 8'h00;

    logic       loop_en = 1'b0;
    logic       tie1 = 1'b0;
    logic       miso_drv = 1'b0;
    bit         sl_cpha = 1'b0;
    int         sl_half = 1;
    logic [7:0] sl_tx = 8'h00;
    int         sl_bit = 7;
    int         sl_edges = 0;
    int         sl_last = 0;
    logic       ssn_prev = 1'b1;
    logic       sck_prev = 1'b0;

    logic       mq[$];
    logic [7:0] rq[$];

    spi_master_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .spe_i       (spe),
        .start_i     (start),
        .tx_data_i   (tx),
        .cpol_i      (cpol),
        .cpha_i      (cpha),
        .spr_i       (spr),
`ifdef SPI_MASTER_CTRL_LSBFIRST_EN
        .lsb_first_i (1'b0),
`endif
        .brg_baud_i  (brg_baud),
        .brg_en_o    (brg_en),
        .brg_clr_o   (brg_clr),
        .brg_spr_o   (brg_spr),
        .ss_n_o      (ss_n),
        .sck_o       (sck),
        .mosi_o      (mosi),
        .miso_i      (miso),
        .rx_data_o   (rx),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (brg_clr) bcnt <= 8'h00;
        else if (brg_en) bcnt <= bcnt + 8'h01;
    end

    assign brg_baud = bcnt[brg_spr];
    assign miso = loop_en ? mosi : (tie1 ? 1'b1 : miso_drv);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sl_drive();
        if (sl_bit >= 0) begin
            miso_drv = sl_tx[sl_bit];
            sl_bit--;
        end
    endtask

    task automatic sl_sample();
        logic e;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            chk("mosi_bit", {31'd0, mosi}, {31'd0, e});
        end
    endtask

    // Slave: edges counted from SS_n fall; sampling/driving edge picked by cpha
    initial begin
        forever begin
            @(negedge clk);
            if (ssn_prev && !ss_n) begin
                sl_edges = 0;
                sl_bit = 7;
                if (!sl_cpha) sl_drive();
            end else if (!ss_n && sck !== sck_prev) begin
                sl_edges++;
                if (sl_edges > 1) chk("sck_half", cyc - sl_last, sl_half);
                sl_last = cyc;
                if ((sl_edges % 2 == 1) != sl_cpha) sl_sample();
                else sl_drive();
            end
            ssn_prev = ss_n;
            sck_prev = sck;
        end
    end

    task automatic start_xfer(input logic [7:0] w, input logic p, input logic h,
                              input logic [2:0] r, input logic [7:0] exp_rx,
                              input logic [7:0] slave_w);
        tx = w;
        cpol = p;
        cpha = h;
        spr = r;
        start = 1'b1;
        sl_cpha = h;
        sl_half = 1 << r;
        sl_tx = slave_w;
        for (int i = 7; i >= 0; i--) mq.push_back(w[i]);
        rq.push_back(exp_rx);
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        chk("ss_n_fall", {31'd0, ss_n}, 32'd0);
    endtask

    task automatic wait_done(input string tag, input int exp_len);
        int n;
        logic [7:0] e;
        n = 0;
        e = 8'hxx;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_len"}, cyc - t_start, exp_len);
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        if (rq.size() > 0) e = rq.pop_front();
        @(negedge clk);
        chk({tag, "_rx"}, {24'd0, rx}, {24'd0, e});
        chk({tag, "_mosi_left"}, mq.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ss_n"}, {31'd0, ss_n}, 32'd1);
        chk({tag, "_sck"}, {31'd0, sck}, 32'd0);
        chk({tag, "_mosi"}, {31'd0, mosi}, 32'd0);
        chk({tag, "_rx"}, {24'd0, rx}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_brg_en"}, {31'd0, brg_en}, 32'd0);
        chk({tag, "_brg_clr"}, {31'd0, brg_clr}, 32'd1);
        chk({tag, "_brg_spr"}, {29'd0, brg_spr}, 32'd0);
    endtask

    initial begin
        bit seen;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0, fastest rate, loopback
        loop_en = 1'b1;
        start_xfer(8'hA5, 1'b0, 1'b0, 3'd0, 8'hA5, 8'h00);
        wait_done("m0", 19);

        // Mode 3, spr=2, MISO held high
        loop_en = 1'b0;
        tie1 = 1'b1;
        cpol = 1'b1;
        @(negedge clk);
        chk("sck_idle_high", {31'd0, sck}, 32'd1);
        start_xfer(8'h3C, 1'b1, 1'b1, 3'd2, 8'hFF, 8'h00);
        wait_done("m3", 73);

        // Mode 1 with mid-transfer config changes, then mode 2
        tie1 = 1'b0;
        @(negedge clk);
        start_xfer(8'h81, 1'b0, 1'b1, 3'd1, 8'h5A, 8'h5A);
        cpol = 1'b1;
        cpha = 1'b0;
        spr = 3'd3;
        tx = 8'h00;
        wait_done("m1", 37);
        @(negedge clk);
        start_xfer(8'h81, 1'b1, 1'b0, 3'd0, 8'h5A, 8'h5A);
        wait_done("m2", 19);

        // Abort with spe after five SCK edges
        loop_en = 1'b1;
        @(negedge clk);
        start_xfer(8'hC3, 1'b0, 1'b0, 3'd0, 8'hC3, 8'h00);
        repeat (7) @(negedge clk);
        spe = 1'b0;
        @(negedge clk);
        chk("abort_edges", sl_edges, 5);
        chk("abort_ss_n", {31'd0, ss_n}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sck", {31'd0, sck}, 32'd0);
        chk("abort_brg_clr", {31'd0, brg_clr}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        chk("abort_rx_keep", {24'd0, rx}, 32'h5A);
        mq.delete();
        rq.delete();
        spe = 1'b1;
        @(negedge clk);

        // Start while busy is ignored; back-to-back start after done
        start_xfer(8'h3C, 1'b0, 1'b0, 3'd0, 8'h3C, 8'h00);
        repeat (4) @(negedge clk);
        tx = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 19);
        start_xfer(8'h96, 1'b0, 1'b0, 3'd0, 8'h96, 8'h00);
        wait_done("b2b", 19);

        // Asynchronous reset in the middle of a transfer
        @(negedge clk);
        start_xfer(8'h55, 1'b0, 1'b0, 3'd1, 8'h55, 8'h00);
        chk("pre_rst_spr", {29'd0, brg_spr}, 32'd1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        mq.delete();
        rq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
